// File: rtl/linescanner_line_packer.sv
// Packs 8-bit line-scan pixels into 32-bit words behind a FWFT FIFO, with line counting and error flags.
// Optional per-line min/max statistics are built only when LINESCANNER_LINE_STATS_EN is defined.
module linescanner_line_packer #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int LINE_LENGTH     = 1024,
  parameter int PIX_CNT_WIDTH   = 16
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        lval,
  input  logic [7:0]  pixel_data,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic [15:0] line_count,
  output logic        line_length_error,
  output logic        overflow,
  input  logic        overflow_clear,
  output logic [7:0]  line_min,
  output logic [7:0]  line_max
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FLUSH, DROP} state_e;

  state_e                     state_q, state_d;
  logic [23:0]                pack_q, pack_d;
  logic [1:0]                 pack_cnt_q, pack_cnt_d;
  logic [31:0]                pend_q, pend_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [PIX_CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic [15:0]                line_count_q;
  logic                       err_q;
  logic                       overflow_q;
  logic [FIFO_ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
  logic [32:0]                mem_q [DEPTH];

  logic        fifo_empty, fifo_full, pop, push, push_ok, push_last, ovf, line_end;
  logic [31:0] push_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]) &&
                      (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0]);
  assign pop        = !fifo_empty && word_ready;
  assign push_ok    = push && !ovf;
  assign pix_cnt_inc = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 1'b1;

  assign word_valid        = !fifo_empty;
  assign word_data         = fifo_empty ? 32'd0 : mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]][31:0];
  assign word_last         = fifo_empty ? 1'b0  : mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]][32];
  assign line_count        = line_count_q;
  assign line_length_error = err_q;
  assign overflow          = overflow_q;

  // A completed word waits in pend_q so the line's final word can be tagged last when lval drops.
  always_comb begin
    state_d    = state_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    pix_cnt_d  = pix_cnt_q;
    push       = 1'b0;
    push_word  = pend_q;
    push_last  = 1'b0;
    line_end   = 1'b0;
    ovf        = 1'b0;
    case (state_q)
      IDLE: if (enable && !lval) state_d = ARMED;
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (lval) begin
          state_d    = CAPTURE;
          pack_d     = {16'd0, pixel_data};
          pack_cnt_d = 2'd1;
          pix_cnt_d  = {{(PIX_CNT_WIDTH-1){1'b0}}, 1'b1};
          pend_vld_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (lval) begin
          pix_cnt_d = pix_cnt_inc;
          if (pack_cnt_q == 2'd3) begin
            pend_d     = {pixel_data, pack_q};
            pend_vld_d = 1'b1;
            pack_d     = 24'd0;
            pack_cnt_d = 2'd0;
            push       = pend_vld_q;
          end else begin
            case (pack_cnt_q)
              2'd0:    pack_d[7:0]   = pixel_data;
              2'd1:    pack_d[15:8]  = pixel_data;
              default: pack_d[23:16] = pixel_data;
            endcase
            pack_cnt_d = pack_cnt_q + 2'd1;
          end
        end else if (pack_cnt_q == 2'd0) begin
          push       = pend_vld_q;
          push_last  = 1'b1;
          pend_vld_d = 1'b0;
          line_end   = 1'b1;
          state_d    = ARMED;
        end else begin
          push       = pend_vld_q;
          pend_vld_d = 1'b0;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        push       = 1'b1;
        push_word  = {8'd0, pack_q};
        push_last  = 1'b1;
        line_end   = 1'b1;
        pack_d     = 24'd0;
        pack_cnt_d = 2'd0;
        state_d    = lval ? DROP : ARMED;
      end
      DROP: if (!lval) state_d = ARMED;
      default: state_d = IDLE;
    endcase
    // A rejected push abandons the line: nothing more is queued and it is not counted.
    ovf = push && fifo_full && !pop;
    if (ovf) begin
      line_end   = 1'b0;
      pend_vld_d = 1'b0;
      pack_d     = 24'd0;
      pack_cnt_d = 2'd0;
      state_d    = lval ? DROP : ARMED;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pack_q       <= 24'd0;
      pack_cnt_q   <= 2'd0;
      pend_q       <= 32'd0;
      pend_vld_q   <= 1'b0;
      pix_cnt_q    <= '0;
      line_count_q <= 16'd0;
      err_q        <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pix_cnt_q  <= pix_cnt_d;
      if (line_end) line_count_q <= line_count_q + 16'd1;
      err_q      <= line_end && (pix_cnt_q != PIX_CNT_WIDTH'(LINE_LENGTH));
      overflow_q <= ovf || (overflow_q && !overflow_clear);
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= {push_last, push_word};
  end

`ifdef LINESCANNER_LINE_STATS_EN
  logic [7:0] cur_min_q, cur_max_q, line_min_q, line_max_q;
  logic       line_start;

  assign line_start = (state_q == ARMED) && enable && lval;

  // Running extremes of the line in progress are published only when the line completes.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      cur_min_q  <= 8'd0;
      cur_max_q  <= 8'd0;
      line_min_q <= 8'd0;
      line_max_q <= 8'd0;
    end else begin
      if (line_start) begin
        cur_min_q <= pixel_data;
        cur_max_q <= pixel_data;
      end else if (state_q == CAPTURE && lval) begin
        if (pixel_data < cur_min_q) cur_min_q <= pixel_data;
        if (pixel_data > cur_max_q) cur_max_q <= pixel_data;
      end
      if (line_end) begin
        line_min_q <= cur_min_q;
        line_max_q <= cur_max_q;
      end
    end
  end

  assign line_min = line_min_q;
  assign line_max = line_max_q;
`else
  assign line_min = 8'd0;
  assign line_max = 8'd0;
`endif

endmodule
